shift_add_mult: RTL and testbench
=================================

// Module: shift_add_mult
// PURPOSE
//  Sequential unsigned N x N shift-and-add multiplier with a 2N-bit product.
//  It sits directly upstream of the team's N-bit ripple adder FA (A, B, Cin -> S, Cout):
//  - drives the adder's operands every iteration;
//  - consumes its sum and carry.
//  One partial product is added per clock. Start/busy/done handshake toward the datapath controller.
// PARAMETERS
//  N   4   operand width in bits (N >= 2); product width is 2N
// PORTS
//  clk     in   1    single clock, rising edge
//  rst     in   1    synchronous, active-high reset
//  start   in   1    request multiply; sampled only in IDLE
//  a       in   N    multiplicand, captured on accepted start
//  b       in   N    multiplier, captured on accepted start
//  busy    out  1    high while an operation is in progress (CALC or DONE)
//  done    out  1    one-cycle pulse: p is valid and updated
//  p       out  2N   product; holds its value until the next done
// BEHAVIOUR
//  Reset: rst=1 at a clock edge puts the FSM in IDLE.
//   - Clears M, ACC, Q, carry, cnt, busy, done and p to 0.
//   - Reset mid-operation aborts the operation; no done pulse is produced.
//  FSM states:
//   - IDLE: start=1 -> M<=a, Q<=b, ACC<=0, cnt<=N, go to CALC.
//   - CALC: once per cycle, then cnt<=cnt-1. When cnt reaches 1 (the Nth iteration), go to DONE.
//   - DONE: p<={ACC,Q}, done=1 for this cycle only, go to IDLE.
//  CALC iteration: drive the adder with A=ACC, B=(Q[0] ? M : 0), Cin=0.
//   - Then shift right: {ACC,Q} <= {Cout,S,Q[N-1:1]}.
//   - Cout is never lost: the sum is N+1 bits before the shift.
//  Latency: start accepted at edge k.
//   - busy is high from cycle k+1 through k+N+1.
//   - done is high in cycle k+N+1; p is valid from that cycle onward.
//   - Throughput is one product per N+2 cycles.
//  Handshake rules:
//   - start while busy is ignored; it is neither queued nor modifies operands.
//   - a and b are don't-care except at the accepted start edge.
//  Width rules: all arithmetic is unsigned.
//   - The product can never exceed 2N bits, since (2^N-1)^2 < 2^2N.
//   - cnt width is $clog2(N+1).
//  Boundary conditions:
//   - a=0 or b=0 gives p=0 after the full N-cycle latency; there is no early exit.
//   - start held high continuously starts a new operation on every IDLE visit,
//     i.e. back-to-back every N+2 cycles.
//   - done and busy are registered outputs; there is no combinational path from start.
// STRUCTURE
//  Shared header mult_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
//   - the CNT_W function/macro.
//  Sub-module: one instance of the existing adder FA #(.N(N)) for the add step.
//   - No other hierarchy.
//  Registers: state, cnt, M[N], ACC[N], Q[N], p[2N], done.
//   - busy is decoded from state.
// TESTING  (N=4 unless noted)
//  1. rst 2 cycles, then idle -> p=0, busy=0, done=0; no activity for 10 cycles.
//  2. a=15, b=15, start 1 cycle -> done exactly 5 cycles after the start edge, p=225;
//     busy high for 5 cycles.
//  3. a=7,b=9 -> p=63; a=0,b=13 -> p=0; a=13,b=1 -> p=13. Each has identical latency.
//  4. a=5,b=3 started; 2 cycles later start with a=15,b=15 -> ignored. p=15, single done.
//  5. a=12,b=11 started; rst asserted in the 3rd CALC cycle -> no done, all outputs 0.
//     A new start of a=12,b=11 then gives p=132.
//  6. N=8, start held high, random a,b over 1000 ops -> every done gives p==a*b;
//     done spacing is exactly 10 cycles.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// Shared types for the shift-and-add multiplier: FSM state encoding and counter sizing.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter must hold the value n itself, not just n-1.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_fa.sv
// N-bit ripple-carry adder; purely combinational, no latency, no backpressure.
module shift_add_mult_fa #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned NxN multiplier, one partial product per clock, 2N-bit product.
// Latency N+1 cycles from accepted start to done; start is ignored while busy.
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = cnt_w(N);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    m;
    logic [N-1:0]    acc;
    logic [N-1:0]    q;
    logic [N-1:0]    addend;
    logic [N-1:0]    sum;
    logic            cout;
    logic [2*N-1:0]  shifted;
    logic            last_iter;

    assign addend    = q[0] ? m : '0;
    // Carry-out becomes the new ACC MSB, so no sum bit is dropped by the shift.
    assign shifted   = {cout, sum, q[N-1:1]};
    assign last_iter = (cnt == CW'(1));

    shift_add_mult_fa #(.N(N)) u_fa (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (start)     state_nxt = ST_CALC;
            ST_CALC: if (last_iter) state_nxt = ST_DONE;
            ST_DONE:                state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            p     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= CW'(N);
                    end
                end
                ST_CALC: begin
                    {acc, q} <= shifted;
                    cnt      <= cnt - CW'(1);
                    // Product is registered on the last iteration so p and done appear together in DONE.
                    if (last_iter) begin
                        p    <= shifted;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: table-driven N=4 products plus corner sequences, and an N=8 back-to-back soak.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4 = 1'b1, start4 = 1'b0, busy4, done4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;

    logic        rst8 = 1'b1, start8 = 1'b0, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    shift_add_mult #(.N(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    shift_add_mult #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  sb4[$];
    logic [15:0] sb8[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        string      name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one N=4 operation and verify latency, busy span, single done and product from the scoreboard.
    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb, input string nm);
        int         done_at;
        int         busy_n;
        int         done_n;
        logic [7:0] got;
        logic [7:0] exp;
        done_at = 0; busy_n = 0; done_n = 0; got = '0;
        @(negedge clk);
        a4 = ta; b4 = tb; start4 = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) start4 = 1'b0;
            if (busy4) busy_n++;
            if (done4) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = j;
                    got     = p4;
                end
            end
            if (j == 6) check({nm, "_p_hold"}, 32'(p4), 32'(got));
        end
        check({nm, "_latency"}, done_at, 5);
        check({nm, "_busy_cycles"}, busy_n, 5);
        check({nm, "_done_count"}, done_n, 1);
        if (sb4.size() == 0) begin
            check({nm, "_scoreboard_empty"}, 1, 0);
        end else begin
            exp = sb4.pop_front();
            check({nm, "_p"}, 32'(got), 32'(exp));
        end
    endtask

    initial begin
        vec_t       vecs[4];
        int         done_n;
        int         done_at;
        logic [7:0] got;
        logic [7:0] exp8;
        int         ops;
        int         last;
        logic [15:0] e16;

        vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'd225, name: "mul_15x15"};
        vecs[1] = '{a: 4'd7,  b: 4'd9,  p: 8'd63,  name: "mul_7x9"};
        vecs[2] = '{a: 4'd0,  b: 4'd13, p: 8'd0,   name: "mul_0x13"};
        vecs[3] = '{a: 4'd13, b: 4'd1,  p: 8'd13,  name: "mul_13x1"};

        // Reset for two cycles, then an idle stretch with no activity.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        check("reset_p", 32'(p4), 0);
        check("reset_busy", 32'(busy4), 0);
        check("reset_done", 32'(done4), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy4), 0);
            check("idle_done", 32'(done4), 0);
        end

        foreach (vecs[i]) begin
            sb4.push_back(vecs[i].p);
            run_op4(vecs[i].a, vecs[i].b, vecs[i].name);
        end

        // A second start while busy must be ignored.
        sb4.push_back(8'd15);
        done_n = 0; done_at = 0; got = '0;
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (done4) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = j;
                    got     = p4;
                end
            end
            if (j == 1) start4 = 1'b0;
            if (j == 2) begin
                a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
            end
            if (j == 3) start4 = 1'b0;
        end
        check("ignored_start_done_count", done_n, 1);
        check("ignored_start_latency", done_at, 5);
        exp8 = sb4.pop_front();
        check("ignored_start_p", 32'(got), 32'(exp8));

        // Reset during the third CALC cycle aborts the operation.
        done_n = 0;
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd11; start4 = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 1) start4 = 1'b0;
            if (j == 3) rst4 = 1'b1;
            if (j == 4) begin
                check("abort_busy", 32'(busy4), 0);
                check("abort_done", 32'(done4), 0);
                check("abort_p", 32'(p4), 0);
                rst4 = 1'b0;
            end
            if (j > 4 && done4) done_n++;
        end
        check("abort_no_done", done_n, 0);
        sb4.push_back(8'd132);
        run_op4(4'd12, 4'd11, "mul_12x11_after_abort");

        // N=8 soak with start held high: every done checked against the scoreboard and spacing.
        @(negedge clk);
        rst8 = 1'b0;
        a8 = 8'($urandom_range(255));
        b8 = 8'($urandom_range(255));
        e16 = 16'(a8) * 16'(b8);
        sb8.push_back(e16);
        start8 = 1'b1;
        ops = 0; last = 0;
        for (int c = 0; c < 10200 && ops < 1000; c++) begin
            @(negedge clk);
            if (done8) begin
                if (sb8.size() == 0) begin
                    check("soak_scoreboard_empty", 1, 0);
                end else begin
                    e16 = sb8.pop_front();
                    check("soak_p", 32'(p8), 32'(e16));
                end
                if (ops > 0) check("soak_spacing", c - last, 10);
                last = c;
                ops++;
                a8 = 8'($urandom_range(255));
                b8 = 8'($urandom_range(255));
                e16 = 16'(a8) * 16'(b8);
                sb8.push_back(e16);
            end
        end
        check("soak_op_count", ops, 1000);
        start8 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
